// File: rtl/lut_config_loader.sv
// Frame controller for a chain of lut config ports: loads host words into the chain,
// or reads the chain back non-destructively by recirculating it through itself.
module lut_config_loader #(
  parameter int CONFIG_WIDTH = 8,
  parameter int CHAIN_WORDS  = 2
) (
  input  logic                    config_clk,
  input  logic                    config_rst,
  input  logic                    start,
  input  logic                    readback,
  input  logic [CONFIG_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [CONFIG_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    chain_en,
  output logic [CONFIG_WIDTH-1:0] chain_din,
  input  logic [CONFIG_WIDTH-1:0] chain_dout,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = (CHAIN_WORDS > 1) ? $clog2(CHAIN_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CHAIN_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Every chain shift is tied to a handshake, so stalls never disturb chain contents.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    chain_en   = 1'b0;
    chain_din  = '0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (start) begin
          state_next = LOAD;
        end else if (readback) begin
          state_next = READ;
        end
      end

      LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid) begin
          chain_en  = 1'b1;
          chain_din = s_data;
          if (count_reg == LAST_WORD) begin
            count_next = '0;
            state_next = DONE;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end

      READ: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = chain_dout;
        // Recirculate the word being handed out so the chain ends where it started.
        if (m_ready) begin
          chain_en  = 1'b1;
          chain_din = chain_dout;
          if (count_reg == LAST_WORD) begin
            count_next = '0;
            state_next = DONE;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: a 2-word frame instance and a 1-word frame instance,
// each driving a behavioural lut shift chain.
module tb_lut_config_loader;

  logic       config_clk = 1'b0;
  logic       config_rst;

  // Two-word instance
  logic       start, readback, s_valid, m_ready;
  logic [7:0] s_data;
  logic       s_ready, m_valid, chain_en, busy, done;
  logic [7:0] m_data, chain_din, chain_dout;
  logic [15:0] mem2;

  // One-word instance
  logic       start1, readback1, s_valid1, m_ready1;
  logic [7:0] s_data1;
  logic       s_ready1, m_valid1, chain_en1, busy1, done1;
  logic [7:0] m_data1, chain_din1, chain_dout1;
  logic [7:0] mem1;

  int checks = 0;
  int errors = 0;

  always #5 config_clk = ~config_clk;

  lut_config_loader #(.CONFIG_WIDTH(8), .CHAIN_WORDS(2)) dut2 (
    .config_clk(config_clk), .config_rst(config_rst),
    .start(start), .readback(readback),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .chain_en(chain_en), .chain_din(chain_din), .chain_dout(chain_dout),
    .busy(busy), .done(done)
  );

  lut_config_loader #(.CONFIG_WIDTH(8), .CHAIN_WORDS(1)) dut1 (
    .config_clk(config_clk), .config_rst(config_rst),
    .start(start1), .readback(readback1),
    .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .chain_en(chain_en1), .chain_din(chain_din1), .chain_dout(chain_dout1),
    .busy(busy1), .done(done1)
  );

  // 16-bit 4-input lut with an 8-bit config port: new word enters low, oldest leaves high.
  always @(posedge config_clk) begin
    if (chain_en) mem2 <= {mem2[7:0], chain_din};
    if (chain_en1) mem1 <= chain_din1;
  end
  assign chain_dout  = mem2[15:8];
  assign chain_dout1 = mem1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge config_clk);
    @(negedge config_clk);
  endtask

  initial begin
    config_rst = 1'b1;
    start = 0; readback = 0; s_valid = 0; m_ready = 0; s_data = 8'h00;
    start1 = 0; readback1 = 0; s_valid1 = 0; m_ready1 = 0; s_data1 = 8'h00;
    tick(); tick();
    config_rst = 1'b0;
    #1;
    check("rst s_ready", s_ready, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst m_valid", m_valid, 0);
    check("rst chain_en", chain_en, 0);
    check("rst chain_din", chain_din, 0);
    check("rst m_data", m_data, 0);

    // Test 1: A5, 3C with s_valid held high
    start = 1; tick(); start = 0;
    check("t1 s_ready", s_ready, 1);
    check("t1 busy", busy, 1);
    s_valid = 1; s_data = 8'hA5; #1;
    check("t1 en w0", chain_en, 1);
    check("t1 din w0", chain_din, 8'hA5);
    tick();
    s_data = 8'h3C; #1;
    check("t1 en w1", chain_en, 1);
    check("t1 din w1", chain_din, 8'h3C);
    tick();
    s_valid = 0; #1;
    check("t1 done", done, 1);
    check("t1 busy done", busy, 0);
    check("t1 s_ready done", s_ready, 0);
    check("t1 mem", mem2, 16'hA53C);
    tick();
    check("t1 done drop", done, 0);

    // Test 3: readback with stalls
    readback = 1; tick(); readback = 0;
    m_ready = 0; #1;
    check("t3 m_valid", m_valid, 1);
    check("t3 m_data w0", m_data, 8'hA5);
    check("t3 en stall", chain_en, 0);
    check("t3 din stall", chain_din, 0);
    tick();
    check("t3 m_data held", m_data, 8'hA5);
    m_ready = 1; #1;
    check("t3 en hs0", chain_en, 1);
    check("t3 din hs0", chain_din, 8'hA5);
    tick();
    m_ready = 0; #1;
    check("t3 m_data w1", m_data, 8'h3C);
    tick();
    check("t3 m_data w1 held", m_data, 8'h3C);
    m_ready = 1; tick(); m_ready = 0; #1;
    check("t3 done", done, 1);
    check("t3 m_valid done", m_valid, 0);
    check("t3 mem", mem2, 16'hA53C);
    tick();

    // Test 4: start and readback together, start ignored mid-LOAD
    start = 1; readback = 1; tick(); start = 0; readback = 0; #1;
    check("t4 s_ready", s_ready, 1);
    check("t4 m_valid", m_valid, 0);
    s_valid = 1; s_data = 8'h77; tick();
    s_valid = 0; start = 1; tick(); start = 0; #1;
    check("t4 still load", s_ready, 1);
    check("t4 no done", done, 0);
    s_valid = 1; s_data = 8'h88; tick(); s_valid = 0; #1;
    check("t4 done", done, 1);
    check("t4 mem", mem2, 16'h7788);
    tick();

    // Test 5: reset after one word
    start = 1; tick(); start = 0;
    s_valid = 1; s_data = 8'h99; tick(); s_valid = 0;
    config_rst = 1; tick(); config_rst = 0; #1;
    check("t5 s_ready", s_ready, 0);
    check("t5 busy", busy, 0);
    check("t5 done", done, 0);
    check("t5 partial", mem2, 16'h8899);
    tick();
    check("t5 no done", done, 0);
    start = 1; tick(); start = 0;
    s_valid = 1; s_data = 8'h11; tick();
    s_data = 8'h22; tick(); s_valid = 0; #1;
    check("t5 done", done, 1);
    check("t5 mem", mem2, 16'h1122);
    tick();

    // Test 2: A5, 3C with a 3-cycle valid gap
    start = 1; tick(); start = 0;
    s_valid = 1; s_data = 8'hA5; tick();
    s_valid = 0; s_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2 gap en", chain_en, 0);
      check("t2 gap din", chain_din, 0);
      check("t2 gap busy", busy, 1);
      tick();
    end
    s_valid = 1; s_data = 8'h3C; tick(); s_valid = 0; #1;
    check("t2 done", done, 1);
    check("t2 mem", mem2, 16'hA53C);
    tick();
    check("t2 idle", busy, 0);

    // Test 6: single-word frame
    start1 = 1; tick(); start1 = 0;
    check("t6 s_ready", s_ready1, 1);
    s_valid1 = 1; s_data1 = 8'h5A; #1;
    check("t6 en", chain_en1, 1);
    tick(); s_valid1 = 0; #1;
    check("t6 done", done1, 1);
    check("t6 en after", chain_en1, 0);
    check("t6 mem", mem1, 8'h5A);
    tick();
    check("t6 done drop", done1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
